aes128_enc_core: RTL and testbench

- Iterative AES-128 encryption core per FIPS-197; one round per clock, on-the-fly key expansion.
- Top-level crypto block: captures a 128-bit plaintext and 128-bit key on a start request and returns the 128-bit ciphertext with a one-cycle valid pulse.
- Encryption only; no decryption, no key caching between blocks.

---
 rtl/aes128_enc_core.sv | 145 ++++++++++++++
 tb/tb_aes128_enc_core.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_enc_core.sv
// rtl/aes128_enc_core.sv - Iterative AES-128 encryption core, one round per clock
// Round keys are expanded on the fly alongside the data rounds.
module aes128_enc_core (
    input  logic         AES_clk,
    input  logic         AES_rst_n,
    input  logic         AES_en,
    input  logic [127:0] AES_data_in,
    input  logic [127:0] AES_key_in,
    output logic [127:0] AES_data_out,
    output logic         AES_data_out_valid
);

    typedef enum logic {IDLE, BUSY} fsm_t;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // 3*a is expressed as xtime(a) ^ a.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    fsm_t         fsm;
    logic         en_d;
    logic [3:0]   round;
    logic [127:0] state;
    logic [127:0] rk;

    logic [31:0]  key_temp;
    logic [127:0] next_rk;
    logic [127:0] sub_shift;
    logic [127:0] mixed;
    logic [127:0] round_out;

    always_comb begin
        key_temp = sub_word({rk[23:0], rk[31:24]}) ^ {rcon(round), 24'h000000};
        next_rk[127:96] = rk[127:96] ^ key_temp;
        next_rk[95:64]  = rk[95:64]  ^ next_rk[127:96];
        next_rk[63:32]  = rk[63:32]  ^ next_rk[95:64];
        next_rk[31:0]   = rk[31:0]   ^ next_rk[63:32];

        // Byte i is row i%4, column i/4; row r rotates left by r columns.
        sub_shift = '0;
        for (int i = 0; i < 16; i++) begin
            sub_shift[127 - 8 * i -: 8] =
                sbox(state[127 - 8 * ((i % 4) + 4 * (((i / 4) + (i % 4)) % 4)) -: 8]);
        end

        mixed = '0;
        for (int c = 0; c < 4; c++) begin
            mixed[127 - 32 * c -: 32] = mix_column(sub_shift[127 - 32 * c -: 32]);
        end

        round_out = ((round == 4'd10) ? sub_shift : mixed) ^ next_rk;
    end

    always_ff @(posedge AES_clk or posedge AES_rst_n) begin
        if (AES_rst_n) begin
            fsm                <= IDLE;
            en_d               <= 1'b0;
            round              <= 4'd0;
            state              <= '0;
            rk                 <= '0;
            AES_data_out       <= '0;
            AES_data_out_valid <= 1'b0;
        end else begin
            en_d               <= AES_en;
            AES_data_out_valid <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (AES_en && !en_d) begin
                        state <= AES_data_in ^ AES_key_in;
                        rk    <= AES_key_in;
                        round <= 4'd1;
                        fsm   <= BUSY;
                    end
                end
                BUSY: begin
                    rk    <= next_rk;
                    state <= round_out;
                    round <= round + 4'd1;
                    if (round == 4'd10) begin
                        AES_data_out       <= round_out;
                        AES_data_out_valid <= 1'b1;
                        fsm                <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_enc_core.sv
// tb/tb_aes128_enc_core.sv - Self-checking bench for aes128_enc_core against a FIPS-197 reference model
module tb_aes128_enc_core;

    logic         AES_clk;
    logic         AES_rst_n;
    logic         AES_en;
    logic [127:0] AES_data_in;
    logic [127:0] AES_key_in;
    logic [127:0] AES_data_out;
    logic         AES_data_out_valid;

    int           tests;
    int           fails;
    logic [127:0] last_out;
    logic [7:0]   sb_tab [256];

    aes128_enc_core dut (
        .AES_clk           (AES_clk),
        .AES_rst_n         (AES_rst_n),
        .AES_en            (AES_en),
        .AES_data_in       (AES_data_in),
        .AES_key_in        (AES_key_in),
        .AES_data_out      (AES_data_out),
        .AES_data_out_valid(AES_data_out_valid)
    );

    initial AES_clk = 1'b0;
    always #5 AES_clk = ~AES_clk;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box derived from its definition: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb_tab[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                        {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i - 1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb_tab[tmp[31:24]], sb_tab[tmp[23:16]], sb_tab[tmp[15:8]], sb_tab[tmp[7:0]]};
                tmp = tmp ^ {rc, 24'h000000};
                rc  = xt(rc);
            end
            w[i] = w[i - 4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8] ^ w[i / 4][31 - 8 * (i % 4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sb_tab[s[i]];
            for (int row = 0; row < 4; row++)
                for (int c = 0; c < 4; c++)
                    t[row + 4 * c] = s[row + 4 * ((c + row) % 4)];
            for (int c = 0; c < 4; c++) begin
                if (r < 10) begin
                    s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
                    s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
                end else begin
                    for (int row = 0; row < 4; row++) s[4*c+row] = t[4*c+row];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4 * r + i / 4][31 - 8 * (i % 4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = s[i];
        return res;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge AES_clk);
        #1;
    endtask

    // Tick 1 is the capture edge k, tick 11 is edge k+10 where the result must appear.
    task automatic run_block(input logic [127:0] pt, input logic [127:0] key,
                             input bit glitch, input string tag);
        logic [127:0] exp;
        int           pulses;
        exp    = aes_ref(pt, key);
        pulses = 0;
        AES_data_in = pt;
        AES_key_in  = key;
        AES_en      = 1'b1;
        for (int t = 1; t <= 11; t++) begin
            tick();
            if (t <= 10 && AES_data_out_valid) pulses++;
            if (t == 2) AES_en = 1'b0;
            if (t == 3) begin
                AES_data_in = {$urandom, $urandom, $urandom, $urandom};
                AES_key_in  = {$urandom, $urandom, $urandom, $urandom};
            end
            if (glitch && t == 4) AES_en = 1'b1;
            if (glitch && t == 6) AES_en = 1'b0;
            if (t == 10) check({tag, " held_prev"}, AES_data_out, last_out);
            if (t == 11) begin
                check({tag, " valid"}, 128'(AES_data_out_valid), 128'd1);
                check({tag, " data"}, AES_data_out, exp);
            end
        end
        check({tag, " early_pulses"}, 128'(pulses), 128'd0);
        last_out = exp;
    endtask

    initial begin
        int pulses;
        int pulse_t;
        tests    = 0;
        fails    = 0;
        last_out = '0;
        AES_rst_n   = 1'b1;
        AES_en      = 1'b0;
        AES_data_in = {$urandom, $urandom, $urandom, $urandom};
        AES_key_in  = {$urandom, $urandom, $urandom, $urandom};
        build_sbox();

        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset data", AES_data_out, 128'd0);
            check("reset valid", 128'(AES_data_out_valid), 128'd0);
        end
        AES_rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle valid", 128'(AES_data_out_valid), 128'd0);
        end
        check("idle data", AES_data_out, 128'd0);

        run_block(128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, "fips_b");
        check("fips_b known", AES_data_out, 128'h3925841d02dc09fbdc118597196a0b32);
        tick();
        check("fips_b drop", 128'(AES_data_out_valid), 128'd0);
        check("fips_b hold", AES_data_out, 128'h3925841d02dc09fbdc118597196a0b32);

        run_block(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f, 1'b0, "fips_c1");
        check("fips_c1 known", AES_data_out, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        tick();

        for (int i = 0; i < 3; i++) begin
            run_block({$urandom, $urandom, $urandom, $urandom},
                      {$urandom, $urandom, $urandom, $urandom}, 1'b0, "random");
            tick();
        end

        AES_data_in = '0;
        AES_key_in  = '0;
        AES_en      = 1'b1;
        pulses      = 0;
        pulse_t     = 0;
        for (int t = 1; t <= 50; t++) begin
            tick();
            if (AES_data_out_valid) begin
                pulses++;
                pulse_t = t;
            end
            if (t == 2) AES_data_in = {$urandom, $urandom, $urandom, $urandom};
        end
        check("held_en pulses", 128'(pulses), 128'd1);
        check("held_en latency", 128'(pulse_t), 128'd11);
        check("held_en data", AES_data_out, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
        last_out = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
        AES_en = 1'b0;
        tick();

        run_block({$urandom, $urandom, $urandom, $urandom},
                  {$urandom, $urandom, $urandom, $urandom}, 1'b1, "busy_restart");
        pulses = 0;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (AES_data_out_valid) pulses++;
        end
        check("busy_restart extra_pulses", 128'(pulses), 128'd0);

        AES_data_in = {$urandom, $urandom, $urandom, $urandom};
        AES_key_in  = {$urandom, $urandom, $urandom, $urandom};
        AES_en      = 1'b1;
        tick();
        AES_en = 1'b0;
        for (int t = 0; t < 5; t++) tick();
        #2;
        AES_rst_n = 1'b1;
        #1;
        check("abort data", AES_data_out, 128'd0);
        check("abort valid", 128'(AES_data_out_valid), 128'd0);
        tick();
        tick();
        AES_rst_n = 1'b0;
        pulses = 0;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (AES_data_out_valid) pulses++;
        end
        check("abort pulses", 128'(pulses), 128'd0);
        check("abort data_after", AES_data_out, 128'd0);
        last_out = '0;
        run_block({$urandom, $urandom, $urandom, $urandom},
                  {$urandom, $urandom, $urandom, $urandom}, 1'b0, "after_reset");

        run_block({$urandom, $urandom, $urandom, $urandom},
                  {$urandom, $urandom, $urandom, $urandom}, 1'b0, "b2b_first");
        run_block(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f, 1'b0, "b2b_second");
        check("b2b_second known", AES_data_out, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        tick();
        check("b2b drop", 128'(AES_data_out_valid), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
